// File: rtl/sseg_pkg.sv
// Shared constants and FSM encoding for the seven-segment display sequencer.
package sseg_pkg;

    localparam logic [7:0] SSEG_CMD_CLEAR      = 8'h76;
    localparam logic [7:0] SSEG_CMD_DP         = 8'h77;
    localparam int         SSEG_FRAME_LEN_DP   = 7;
    localparam int         SSEG_FRAME_LEN_NODP = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_REL  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } sseg_state_t;

    function automatic logic [7:0] sseg_nibble(input logic [3:0] n);
        return {4'h0, n};
    endfunction

endpackage

// File: rtl/sseg_ctrl_if.sv
// Byte handshake between the display sequencer and the SPI byte sender.
interface sseg_ctrl_if;
    logic       req;
    logic [7:0] dat;
    logic       snt;

    modport master (output req, output dat, input snt);
    modport slave  (input req, input dat, output snt);
endinterface

// File: rtl/sseg_frame_rom.sv
// Maps a byte index within the display frame to the byte value; flags the final byte.
module sseg_frame_rom
    import sseg_pkg::*;
#(
    parameter bit SEND_DP = 1'b1
) (
    input  logic [2:0]  i_idx,
    input  logic [15:0] i_val,
    input  logic [3:0]  i_dp,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    localparam int         LP_LEN  = SEND_DP ? SSEG_FRAME_LEN_DP : SSEG_FRAME_LEN_NODP;
    localparam logic [2:0] LP_LAST = 3'(LP_LEN - 1);
    localparam logic [2:0] LP_HDR  = SEND_DP ? 3'd3 : 3'd1;

    logic [1:0] w_dig;

    // digit slot counted from the first digit byte after the command header
    assign w_dig = 2'(i_idx - LP_HDR);

    always_comb begin
        o_byte = 8'h00;
        if (i_idx == 3'd0) begin
            o_byte = SSEG_CMD_CLEAR;
        end else if (SEND_DP && i_idx == 3'd1) begin
            o_byte = SSEG_CMD_DP;
        end else if (SEND_DP && i_idx == 3'd2) begin
            o_byte = sseg_nibble(i_dp);
        end else begin
            case (w_dig)
                2'd0:    o_byte = sseg_nibble(i_val[15:12]);
                2'd1:    o_byte = sseg_nibble(i_val[11:8]);
                2'd2:    o_byte = sseg_nibble(i_val[7:4]);
                default: o_byte = sseg_nibble(i_val[3:0]);
            endcase
        end
    end

    assign o_last = (i_idx == LP_LAST);

endmodule

// File: rtl/sseg_ctrl.sv
// Display frame sequencer: latches value/dp on update and streams the frame bytes over req/snt.
module sseg_ctrl
    import sseg_pkg::*;
#(
    parameter int GAP_CYC = 100,
    parameter bit SEND_DP = 1'b1,
    parameter int GAP_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd,
    input  logic [15:0] val,
    input  logic [3:0]  dp,
    output logic        busy,
    output logic        done,
    sseg_ctrl_if.master spi
);

    localparam bit               LP_HAS_GAP  = (GAP_CYC > 0);
    localparam logic [GAP_W-1:0] LP_GAP_INIT = LP_HAS_GAP ? GAP_W'(GAP_CYC - 1) : '0;

    sseg_state_t      r_state;
    sseg_state_t      w_state_nxt;
    logic [2:0]       r_idx;
    logic [15:0]      r_val_l;
    logic [3:0]       r_dp_l;
    logic             r_pend;
    logic [GAP_W-1:0] r_gap;

    logic       w_start;
    logic       w_rel_exit;
    logic       w_adv;
    logic       w_last;
    logic [7:0] w_byte;

    // a start is held off while the sender still reports a byte from before a reset
    assign w_start    = (r_state == ST_IDLE) && (upd || r_pend) && !spi.snt;
    assign w_rel_exit = (r_state == ST_REL) && !spi.snt;
    assign w_adv      = (w_rel_exit && !w_last && !LP_HAS_GAP) ||
                        ((r_state == ST_GAP) && (r_gap == '0));

    sseg_frame_rom #(
        .SEND_DP (SEND_DP)
    ) u_rom (
        .i_idx  (r_idx),
        .i_val  (r_val_l),
        .i_dp   (r_dp_l),
        .o_byte (w_byte),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_REQ;
            ST_REQ:  if (spi.snt) w_state_nxt = ST_REL;
            ST_REL: begin
                if (!spi.snt) begin
                    if (w_last)          w_state_nxt = ST_DONE;
                    else if (LP_HAS_GAP) w_state_nxt = ST_GAP;
                    else                 w_state_nxt = ST_LOAD;
                end
            end
            ST_GAP:  if (r_gap == '0) w_state_nxt = ST_LOAD;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_idx  <= 3'd0;
            r_gap  <= '0;
        end else begin
            // any update that does not start a frame right now is remembered, one deep
            if (w_start) begin
                r_pend <= 1'b0;
            end else if (upd) begin
                r_pend <= 1'b1;
            end

            if (w_start) begin
                r_idx <= 3'd0;
            end else if (w_adv) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_rel_exit && !w_last) begin
                r_gap <= LP_GAP_INIT;
            end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_val_l <= val;
            r_dp_l  <= dp;
        end
    end

    always_comb begin
        spi.req = (r_state == ST_REQ);
        spi.dat = (r_state == ST_IDLE) ? 8'h00 : w_byte;
        busy    = (r_state != ST_IDLE) || r_pend;
        done    = (r_state == ST_DONE);
    end

endmodule

// File: tb/tb_sseg_ctrl.sv
// Scoreboard bench: two sequencers (gap 4 with dp bytes, gap 0 without) share one stimulus stream.
module tb_sseg_ctrl;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
    } frame_t;

    bit          clk = 1'b0;
    logic        rst_n;
    logic        upd;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [1:0]  busy_a, done_a, req_a, snt_a;
    logic [7:0]  dat_a [2];

    sseg_ctrl_if if0 ();
    sseg_ctrl_if if1 ();

    sseg_ctrl #(.GAP_CYC(4), .SEND_DP(1'b1), .GAP_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .upd(upd), .val(val), .dp(dp),
        .busy(busy_a[0]), .done(done_a[0]), .spi(if0.master));

    sseg_ctrl #(.GAP_CYC(0), .SEND_DP(1'b0), .GAP_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .upd(upd), .val(val), .dp(dp),
        .busy(busy_a[1]), .done(done_a[1]), .spi(if1.master));

    bit snt_r [2];
    assign if0.snt  = snt_r[0];
    assign if1.snt  = snt_r[1];
    assign req_a[0] = if0.req;
    assign req_a[1] = if1.req;
    assign dat_a[0] = if0.dat;
    assign dat_a[1] = if1.dat;
    assign snt_a[0] = snt_r[0];
    assign snt_a[1] = snt_r[1];

    always #5 clk = ~clk;

    frame_t frames[$];
    int     n_done_exp = 0;
    bit     to_flag = 1'b0;
    bit     fin_req = 1'b0;
    bit     fin_ack = 1'b0;
    int     checks = 0;
    int     errors = 0;

    // SPI sender model: no reset, finishes a started byte, holds snt until req drops
    bit s_busy [2];
    int s_cnt  [2];
    int s_tgt  [2];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (s_busy[g]) begin
                if (s_cnt[g] >= s_tgt[g]) begin
                    s_busy[g] = 1'b0;
                    snt_r[g] <= 1'b1;
                end else begin
                    s_cnt[g]++;
                end
            end else if (snt_r[g]) begin
                if (!req_a[g]) snt_r[g] <= 1'b0;
            end else if (req_a[g]) begin
                s_busy[g] = 1'b1;
                s_cnt[g]  = 1;
                s_tgt[g]  = 16 + int'($urandom_range(0, 7));
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [15:0] v, input logic [3:0] d,
                                            input bit sdp, input int i);
        logic [7:0] b[$];
        b.push_back(8'h76);
        if (sdp) begin
            b.push_back(8'h77);
            b.push_back({4'h0, d});
        end
        for (int k = 3; k >= 0; k--) b.push_back({4'h0, 4'((v >> (4 * k)) & 16'hF)});
        return (i < b.size()) ? b[i] : 8'h00;
    endfunction

    task automatic chk(input bit ok, input string nm, input int g, input int act, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h", nm, g, act, want);
        end
    endtask

    bit rst_q = 1'b0;
    bit seen_edge = 1'b0;
    always @(posedge clk) begin
        rst_q     <= rst_n;
        seen_edge <= 1'b1;
    end

    bit         prev_req [2], prev_snt [2], prev_done [2], unstable [2];
    logic [7:0] cap_dat  [2];
    int         bptr [2], fptr [2], tsf [2], done_cnt [2], lat [2], bchk [2];

    always @(negedge clk) begin
        if (seen_edge) begin
            for (int g = 0; g < 2; g++) begin
                int  gapc, len;
                bit  sdp;
                gapc = (g == 0) ? 4 : 0;
                len  = (g == 0) ? 7 : 5;
                sdp  = (g == 0);
                if (!rst_q) begin
                    chk(!req_a[g] && !busy_a[g] && !done_a[g] && dat_a[g] == 8'h00, "reset_state", g,
                        {req_a[g], busy_a[g], done_a[g], dat_a[g]}, 0);
                    if (bptr[g] != 0) begin
                        fptr[g]++;
                        bptr[g] = 0;
                    end
                    lat[g]  = 0;
                    bchk[g] = -1;
                    tsf[g]  = 1000;
                end else begin
                    if (lat[g] == 2) begin
                        chk(!req_a[g] && busy_a[g], "start_cycle", g, {req_a[g], busy_a[g]}, 1);
                        lat[g] = 1;
                    end else if (lat[g] == 1) begin
                        chk(req_a[g], "req_latency", g, req_a[g], 1);
                        lat[g] = 0;
                    end
                    if (upd && !busy_a[g] && !snt_a[g]) lat[g] = 2;

                    if (prev_snt[g] && !snt_a[g]) tsf[g] = 0;
                    else tsf[g]++;

                    if (req_a[g] && prev_req[g] && dat_a[g] != cap_dat[g]) unstable[g] = 1'b1;

                    if (req_a[g] && !prev_req[g]) begin
                        chk(!snt_a[g], "req_while_snt", g, snt_a[g], 0);
                        if (bptr[g] > 0 && bptr[g] < len)
                            chk(tsf[g] == gapc + 2, "gap_cycles", g, tsf[g], gapc + 2);
                        if (fptr[g] < frames.size() && bptr[g] < len) begin
                            logic [7:0] eb;
                            eb = exp_byte(frames[fptr[g]].v, frames[fptr[g]].d, sdp, bptr[g]);
                            chk(dat_a[g] == eb, "byte", g, dat_a[g], eb);
                        end else begin
                            chk(1'b0, "extra_byte", g, bptr[g], len);
                        end
                        bptr[g]++;
                        cap_dat[g]  = dat_a[g];
                        unstable[g] = 1'b0;
                    end

                    if (!req_a[g] && prev_req[g])
                        chk(!unstable[g] && dat_a[g] == cap_dat[g], "dat_stable", g, dat_a[g], cap_dat[g]);

                    if (bchk[g] >= 0) begin
                        chk(busy_a[g] == bchk[g][0], "busy_after_done", g, busy_a[g], bchk[g]);
                        bchk[g] = -1;
                    end

                    if (done_a[g]) begin
                        chk(!prev_done[g] && bptr[g] == len, "done_pulse", g, bptr[g], len);
                        done_cnt[g]++;
                        bchk[g] = (frames.size() > fptr[g] + 1) ? 1 : 0;
                        fptr[g]++;
                        bptr[g] = 0;
                    end
                end
                prev_req[g]  = req_a[g];
                prev_snt[g]  = snt_a[g];
                prev_done[g] = done_a[g];
            end
            if (fin_req && !fin_ack) begin
                for (int g = 0; g < 2; g++) begin
                    chk(done_cnt[g] == n_done_exp, "done_count", g, done_cnt[g], n_done_exp);
                    chk(fptr[g] == frames.size(), "frames_consumed", g, fptr[g], frames.size());
                    chk(!busy_a[g], "busy_final", g, busy_a[g], 0);
                end
                chk(!to_flag, "timeout", 0, to_flag, 0);
                fin_ack = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] d, input bit completes);
        frame_t f;
        f.v = v;
        f.d = d;
        frames.push_back(f);
        if (completes) n_done_exp++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        if (to_flag) return;
        while ((busy_a != 2'b00 || snt_a != 2'b00) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) to_flag = 1'b1;
    endtask

    task automatic wait_req_rises(input int cnt);
        int seen, cyc;
        bit pr;
        seen = 0;
        cyc  = 0;
        pr   = req_a[0];
        while (seen < cnt && cyc < 500) begin
            tick();
            cyc++;
            if (req_a[0] && !pr) seen++;
            pr = req_a[0];
        end
        if (seen < cnt) to_flag = 1'b1;
    endtask

    task automatic start_frame(input logic [15:0] v, input logic [3:0] d, input bit completes);
        val = v;
        dp  = d;
        push(v, d, completes);
        pulse();
    endtask

    initial begin
        rst_n = 1'b0;
        upd   = 1'b0;
        val   = 16'h0000;
        dp    = 4'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        start_frame(16'h1234, 4'b0100, 1'b1);
        wait_idle();
        start_frame(16'hABCD, 4'b1010, 1'b1);
        wait_idle();

        // update collapsing while a frame is in flight
        start_frame(16'h1111, 4'b0011, 1'b1);
        wait_req_rises(3);
        val = 16'h2222;
        push(16'h2222, 4'b0011, 1'b1);
        pulse();
        tick();
        pulse();
        wait_idle();

        for (int it = 0; it < 20 && !to_flag; it++) begin
            int mode;
            start_frame(16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                repeat ($urandom_range(20, 40)) tick();
                val = 16'($urandom);
                dp  = 4'($urandom_range(0, 15));
                push(val, dp, 1'b1);
                pulse();
                tick();
                pulse();
            end else if (mode == 2) begin
                repeat (10) tick();
                val = 16'($urandom);
                dp  = 4'($urandom_range(0, 15));
            end
            wait_idle();
        end

        // reset while the third byte is being requested, then restart behind the sender
        start_frame(16'h5678, 4'b0001, 1'b0);
        wait_req_rises(3);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (!snt_a[0] && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) to_flag = 1'b1;
        end
        start_frame(16'h9ABC, 4'b0010, 1'b1);
        tick();
        wait_idle();

        repeat (3) tick();
        fin_req = 1'b1;
        begin
            int n;
            n = 0;
            while (!fin_ack && n < 20) begin
                tick();
                n++;
            end
        end
        if (!fin_ack) begin
            $display("FAIL final_checks not reached");
            $fatal(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
